train_scheduler: RTL and testbench
==================================

Name: train_scheduler

Overview:
- Sequences the on-chip training loop: first forward pass with initial weights, forward passes with updated weights, backprop, then a clear phase.
- Runs this loop for a programmed number of epochs.
- Drives the f0/f1/backprop enables and zero strobes consumed by the hidden/output neurons and backprop units.
- Collects their completion flags, adds per-phase watchdog timeout, abort and a done/error handshake.

Parameters:
- N_BP, 4, number of backprop units whose b_end flags must all be seen.
- EPOCH_W, 8, width of epoch count/progress.
- TO_W, 8, width of phase watchdog counter.
- TIMEOUT, 200, max cycles allowed in any FWD/BWD/CLR phase (must be < 2**TO_W).

Ports:
- clk_i  in  1  clock
- rst_i  in  1  reset, asynchronous, active-low
- en_i  in  1  global enable; low freezes state, counters, watchdog, outputs
- init_i  in  1  start request; rising edge detected internally
- epochs_i  in  EPOCH_W  epochs to run, latched at start
- abort_i  in  1  synchronous abort, highest priority
- f_end_i  in  1  output neuron forward-pass complete
- b_end_i  in  N_BP  per-unit backprop complete (may pulse at different cycles)
- zero_end_check_i  in  1  clear phase complete
- f0_pass_o  out  1  forward pass with init weights (epoch 0)
- f1_pass_o  out  1  forward pass with updated weights (epoch>0)
- b_pass_o  out  1  backprop enable
- zero_loss_o / zero_final_o / zero_weight_update_o  out  1 each  clear strobes
- busy_o  out  1  not IDLE/ERR
- done_o  out  1  one-cycle completion pulse
- err_o  out  1  sticky watchdog error
- epoch_o  out  EPOCH_W  epochs completed in current run

Behaviour:
- Reset (rst_i low, async): state IDLE; all outputs 0; epoch_o=0; b_end mask=0; watchdog=0; init edge register=0.
- Outputs are registered and Moore-decoded from state; no input-to-output combinational path.
- States: IDLE, FWD, BWD, CLR, ERR.
- IDLE:
  - init_i rising edge with epochs_i!=0: latch epochs_i, epoch_o=0, go FWD. Edge sampled at cycle N → f0_pass_o high at N+1.
  - epochs_i==0: done_o pulses next cycle; stay IDLE.
- FWD:
  - f0_pass_o=1 if epoch_o==0, else f1_pass_o=1.
  - On f_end_i go BWD; clear b_end mask on entry.
- BWD:
  - b_pass_o=1; mask |= b_end_i each cycle.
  - Leave for CLR the cycle after mask is all-ones, counting flags arriving that cycle.
- CLR:
  - All three zero strobes high.
  - On zero_end_check_i: epoch_o+1.
  - If new epoch_o==latched count: go IDLE, done_o pulse on the IDLE entry cycle.
  - Otherwise go FWD (f1).
- Watchdog:
  - Resets to 0 on every state entry and increments each enabled cycle in FWD/BWD/CLR.
  - On reaching TIMEOUT-1 without the exit condition: go ERR.
  - If the exit condition arrives in that same cycle, the exit wins.
- ERR: err_o=1, all pass/zero outputs 0, busy_o=0; init_i ignored; leave only via abort_i or reset.
- abort_i:
  - Any state → IDLE next cycle; clears err_o, epoch_o, mask and watchdog; no done_o.
  - Beats every other event in the same cycle.
- init_i while busy: ignored; a held-high init_i does not retrigger after completion (edge only).
- en_i low:
  - Everything holds, including done_o; edge detector does not sample.
  - Resumes exactly where it stopped.
- epoch_o wraps never: the latched count bounds it.
- Reset mid-run: immediate return to reset values.

Decomposition:
- Shared package train_pkg: state enum (IDLE, FWD, BWD, CLR, ERR), default EPOCH_W/TO_W/TIMEOUT constants, N_BP.
- One sub-module, phase_timer: loadable watchdog counter with clear, enable and expire output, parameterised by TO_W/TIMEOUT.

Test Plan:
- Single epoch:
  - Stimulus: epochs_i=1, init edge; f_end_i 5 cycles later; b_end_i bits 0..3 pulsed on separate cycles; zero_end_check_i 3 cycles later.
  - Required: f0_pass_o → b_pass_o → zeros in order; done_o one pulse; epoch_o=1; f1_pass_o never high.
- Three epochs:
  - Stimulus: epochs_i=3.
  - Required: f0_pass_o in epoch 0, f1_pass_o in epochs 1 and 2; epoch_o steps 0,1,2,3; one done_o.
- Watchdog:
  - Stimulus: withhold b_end_i[2].
  - Required: ERR after TIMEOUT cycles in BWD; err_o=1; outputs 0; abort_i → IDLE, err_o=0.
- Boundary timeout:
  - Stimulus: f_end_i asserted on the watchdog's final cycle.
  - Required: goes to BWD, not ERR.
- Abort and retrigger:
  - Stimulus: abort_i in FWD together with f_end_i.
  - Required: IDLE next cycle, no done_o; init_i held high afterwards does not restart until a new rising edge.
- Freeze, zero epochs and reset:
  - en_i low for 10 cycles mid-BWD holds all state and b_end mask; a b_end pulse during freeze is not captured.
  - epochs_i=0 gives an immediate done_o.
  - Async reset mid-CLR clears all outputs without a clock edge.

Source files
------------

// File: rtl/train_pkg.sv
// Shared types and defaults for the on-chip training sequencer.
// Holds the phase state encoding and sizing constants.
package train_pkg;

    localparam int N_BP    = 4;
    localparam int EPOCH_W = 8;
    localparam int TO_W    = 8;
    localparam int TIMEOUT = 200;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FWD,
        S_BWD,
        S_CLR,
        S_ERR
    } state_e;

    function automatic logic is_active(state_e s);
        return (s == S_FWD) || (s == S_BWD) || (s == S_CLR);
    endfunction

endpackage

// File: rtl/phase_timer.sv
// Per-phase watchdog: cleared on phase entry, counts enabled cycles,
// flags expiry on the last allowed cycle of a phase.
module phase_timer #(
    parameter int TO_W    = 8,
    parameter int TIMEOUT = 200
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic en_i,
    input  logic clr_i,
    output logic expire_o
);

    logic [TO_W-1:0] cnt_q;
    logic [TO_W-1:0] cnt_d;

    assign expire_o = (cnt_q == TO_W'(TIMEOUT - 1));

    // Next count: clear wins, otherwise count up and saturate at expiry
    always_comb begin
        cnt_d = cnt_q;
        if (en_i) begin
            if (clr_i) begin
                cnt_d = '0;
            end else if (!expire_o) begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    // Counter register
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/train_scheduler.sv
// Training loop sequencer: forward, backprop and clear phases per epoch,
// with watchdog, abort and done/error handshake. Outputs are registered.
module train_scheduler
    import train_pkg::*;
#(
    parameter int N_BP    = train_pkg::N_BP,
    parameter int EPOCH_W = train_pkg::EPOCH_W,
    parameter int TO_W    = train_pkg::TO_W,
    parameter int TIMEOUT = train_pkg::TIMEOUT
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               en_i,
    input  logic               init_i,
    input  logic [EPOCH_W-1:0] epochs_i,
    input  logic               abort_i,
    input  logic               f_end_i,
    input  logic [N_BP-1:0]    b_end_i,
    input  logic               zero_end_check_i,
    output logic               f0_pass_o,
    output logic               f1_pass_o,
    output logic               b_pass_o,
    output logic               zero_loss_o,
    output logic               zero_final_o,
    output logic               zero_weight_update_o,
    output logic               busy_o,
    output logic               done_o,
    output logic               err_o,
    output logic [EPOCH_W-1:0] epoch_o
);

    state_e             state_q, state_d;
    logic [EPOCH_W-1:0] epoch_q, epoch_d;
    logic [EPOCH_W-1:0] lat_q, lat_d;
    logic [N_BP-1:0]    mask_q, mask_d;
    logic               init_q, init_d;
    logic               done_q, done_d;
    logic               f0_q, f0_d;
    logic               f1_q, f1_d;
    logic               b_q, b_d;
    logic               z_q, z_d;
    logic               busy_q, busy_d;
    logic               err_q, err_d;
    logic               rise;
    logic               expire;
    logic               tmr_clr;

    assign rise    = init_i & ~init_q;
    assign tmr_clr = (state_d != state_q) || !is_active(state_q);

    phase_timer #(
        .TO_W    (TO_W),
        .TIMEOUT (TIMEOUT)
    ) u_timer (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .en_i     (en_i),
        .clr_i    (tmr_clr),
        .expire_o (expire)
    );

    // Phase sequencing; exit conditions beat the watchdog, abort beats all
    always_comb begin
        state_d = state_q;
        epoch_d = epoch_q;
        lat_d   = lat_q;
        mask_d  = mask_q;
        init_d  = init_q;
        done_d  = done_q;
        if (en_i) begin
            init_d = init_i;
            done_d = 1'b0;
            if (abort_i) begin
                state_d = S_IDLE;
                epoch_d = '0;
                mask_d  = '0;
            end else begin
                unique case (state_q)
                    S_IDLE: begin
                        if (rise) begin
                            epoch_d = '0;
                            if (epochs_i != '0) begin
                                lat_d   = epochs_i;
                                state_d = S_FWD;
                            end else begin
                                done_d = 1'b1;
                            end
                        end
                    end
                    S_FWD: begin
                        if (f_end_i) begin
                            state_d = S_BWD;
                            mask_d  = '0;
                        end else if (expire) begin
                            state_d = S_ERR;
                        end
                    end
                    S_BWD: begin
                        mask_d = mask_q | b_end_i;
                        if (&mask_d) begin
                            state_d = S_CLR;
                        end else if (expire) begin
                            state_d = S_ERR;
                        end
                    end
                    S_CLR: begin
                        if (zero_end_check_i) begin
                            epoch_d = epoch_q + 1'b1;
                            if (epoch_d == lat_q) begin
                                state_d = S_IDLE;
                                done_d  = 1'b1;
                            end else begin
                                state_d = S_FWD;
                            end
                        end else if (expire) begin
                            state_d = S_ERR;
                        end
                    end
                    S_ERR: begin
                        state_d = S_ERR;
                    end
                    default: begin
                        state_d = S_IDLE;
                    end
                endcase
            end
        end
    end

    // Moore decode of the next state into registered outputs
    always_comb begin
        f0_d   = (state_d == S_FWD) && (epoch_d == '0);
        f1_d   = (state_d == S_FWD) && (epoch_d != '0);
        b_d    = (state_d == S_BWD);
        z_d    = (state_d == S_CLR);
        busy_d = is_active(state_d);
        err_d  = (state_d == S_ERR);
    end

    // State, counters and output registers
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q <= S_IDLE;
            epoch_q <= '0;
            lat_q   <= '0;
            mask_q  <= '0;
            init_q  <= 1'b0;
            done_q  <= 1'b0;
            f0_q    <= 1'b0;
            f1_q    <= 1'b0;
            b_q     <= 1'b0;
            z_q     <= 1'b0;
            busy_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            epoch_q <= epoch_d;
            lat_q   <= lat_d;
            mask_q  <= mask_d;
            init_q  <= init_d;
            done_q  <= done_d;
            f0_q    <= f0_d;
            f1_q    <= f1_d;
            b_q     <= b_d;
            z_q     <= z_d;
            busy_q  <= busy_d;
            err_q   <= err_d;
        end
    end

    assign f0_pass_o            = f0_q;
    assign f1_pass_o            = f1_q;
    assign b_pass_o             = b_q;
    assign zero_loss_o          = z_q;
    assign zero_final_o         = z_q;
    assign zero_weight_update_o = z_q;
    assign busy_o               = busy_q;
    assign done_o               = done_q;
    assign err_o                = err_q;
    assign epoch_o              = epoch_q;

endmodule

// File: tb/tb_train_scheduler.sv
// Directed bench for train_scheduler with an expected-epoch scoreboard.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_train_scheduler;

    localparam int TMO = 200;

    logic       clk;
    logic       rst_n;
    logic       en;
    logic       init;
    logic [7:0] epochs;
    logic       abort;
    logic       f_end;
    logic [3:0] b_end;
    logic       zero_end;
    logic       f0, f1, bp, zl, zf, zw, busy, done, err;
    logic [7:0] epoch;

    int n_assert = 0;
    int n_fail   = 0;
    int f1_cnt   = 0;
    int done_cnt = 0;
    int sb[$];

    train_scheduler dut (
        .clk_i                (clk),
        .rst_i                (rst_n),
        .en_i                 (en),
        .init_i               (init),
        .epochs_i             (epochs),
        .abort_i              (abort),
        .f_end_i              (f_end),
        .b_end_i              (b_end),
        .zero_end_check_i     (zero_end),
        .f0_pass_o            (f0),
        .f1_pass_o            (f1),
        .b_pass_o             (bp),
        .zero_loss_o          (zl),
        .zero_final_o         (zf),
        .zero_weight_update_o (zw),
        .busy_o               (busy),
        .done_o               (done),
        .err_o                (err),
        .epoch_o              (epoch)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        #2;
        if (f1) f1_cnt++;
        if (done) done_cnt++;
    end

    task automatic step(input int n = 1);
        repeat (n) @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp_v);
        n_assert++;
        assert (obs === exp_v) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
        end
    endtask

    task automatic expect_done(input string tag);
        int exp_e;
        chk({tag, "_done"}, 32'(done), 1);
        chk({tag, "_sb_nonempty"}, 32'(sb.size() != 0), 1);
        exp_e = (sb.size() != 0) ? sb.pop_front() : -1;
        chk({tag, "_epoch"}, 32'(epoch), 32'(exp_e));
        chk({tag, "_idle"}, 32'(busy), 0);
    endtask

    function automatic logic [8:0] outs();
        return {f0, f1, bp, zl, zf, zw, busy, done, err};
    endfunction

    initial begin
        int n;
        int base;
        rst_n = 1'b0; en = 1'b1; init = 1'b0; epochs = '0; abort = 1'b0;
        f_end = 1'b0; b_end = '0; zero_end = 1'b0;
        step(2);
        chk("reset_outs", 32'(outs()), 0);
        chk("reset_epoch", 32'(epoch), 0);
        rst_n = 1'b1;
        step();

        // single epoch
        base = f1_cnt;
        epochs = 8'd1; sb.push_back(1);
        init = 1'b1; step(); init = 1'b0;
        chk("t1_f0", 32'({f0, f1, busy}), 32'b101);
        step(4);
        f_end = 1'b1; step(); f_end = 1'b0;
        chk("t1_bwd", 32'({f0, bp}), 32'b01);
        for (int i = 0; i < 4; i++) begin
            b_end = 4'(1 << i); step(); b_end = '0;
            if (i < 3) chk("t1_bwd_hold", 32'({bp, zl}), 32'b10);
        end
        chk("t1_clr", 32'({bp, zl, zf, zw}), 32'b0111);
        step(2);
        zero_end = 1'b1; step(); zero_end = 1'b0;
        expect_done("t1");
        step();
        chk("t1_done_pulse", 32'(done), 0);
        chk("t1_no_f1", 32'(f1_cnt - base), 0);

        // three epochs
        epochs = 8'd3; sb.push_back(3);
        init = 1'b1; step(); init = 1'b0;
        for (int e = 0; e < 3; e++) begin
            chk("t2_fwd", 32'({f0, f1}), (e == 0) ? 32'b10 : 32'b01);
            chk("t2_epoch", 32'(epoch), 32'(e));
            f_end = 1'b1; step(); f_end = 1'b0;
            chk("t2_bwd", 32'(bp), 1);
            b_end = 4'hf; step(); b_end = '0;
            chk("t2_clr", 32'({zl, zf, zw}), 32'b111);
            zero_end = 1'b1; step(); zero_end = 1'b0;
            chk("t2_epoch_step", 32'(epoch), 32'(e + 1));
        end
        expect_done("t2");
        step();
        chk("t2_done_pulse", 32'(done), 0);

        // watchdog in backprop
        epochs = 8'd1;
        init = 1'b1; step(); init = 1'b0;
        f_end = 1'b1; step(); f_end = 1'b0;
        b_end = 4'hb; step(); b_end = '0;
        n = 1;
        while (!err && n < 400) begin
            step();
            n++;
        end
        chk("t3_cycles", 32'(n), TMO);
        chk("t3_err_outs", 32'(outs()), 32'b1);
        init = 1'b1; step(); init = 1'b0; step();
        chk("t3_err_sticky", 32'({busy, err}), 32'b01);
        abort = 1'b1; step(); abort = 1'b0;
        chk("t3_abort", 32'(outs()), 0);
        chk("t3_abort_epoch", 32'(epoch), 0);

        // f_end on final watchdog cycle
        epochs = 8'd1; sb.push_back(1);
        init = 1'b1; step(); init = 1'b0;
        step(TMO - 1);
        chk("t4_last_cycle", 32'({f0, err}), 32'b10);
        f_end = 1'b1; step(); f_end = 1'b0;
        chk("t4_bwd", 32'({bp, err}), 32'b10);
        b_end = 4'hf; step(); b_end = '0;
        zero_end = 1'b1; step(); zero_end = 1'b0;
        expect_done("t4");

        // abort with f_end, held init
        step();
        epochs = 8'd2;
        init = 1'b1; step();
        chk("t5_fwd", 32'(f0), 1);
        base = done_cnt;
        abort = 1'b1; f_end = 1'b1; step(); abort = 1'b0; f_end = 1'b0;
        chk("t5_abort", 32'(outs()), 0);
        step(5);
        chk("t5_no_retrig", 32'(busy), 0);
        chk("t5_no_done", 32'(done_cnt - base), 0);
        init = 1'b0; step(); init = 1'b1; step(); init = 1'b0;
        chk("t5_new_edge", 32'({f0, busy}), 32'b11);
        abort = 1'b1; step(); abort = 1'b0;
        chk("t5_abort2", 32'(busy), 0);

        // freeze mid-backprop
        epochs = 8'd1; sb.push_back(1);
        init = 1'b1; step(); init = 1'b0;
        f_end = 1'b1; step(); f_end = 1'b0;
        b_end = 4'h3; step(); b_end = '0;
        en = 1'b0; step();
        b_end = 4'h4; step(); b_end = '0;
        step(8);
        chk("t6_frozen", 32'({bp, zl, busy}), 32'b101);
        en = 1'b1;
        b_end = 4'h8; step(); b_end = '0;
        chk("t6_mask_held", 32'({bp, zl}), 32'b10);
        b_end = 4'h4; step(); b_end = '0;
        chk("t6_clr", 32'({zl, zf, zw}), 32'b111);
        zero_end = 1'b1; step(); zero_end = 1'b0;
        en = 1'b0;
        expect_done("t6");
        step(3);
        chk("t6_done_held", 32'(done), 1);
        en = 1'b1; step();
        chk("t6_done_drop", 32'(done), 0);

        // zero epochs
        epochs = 8'd0; sb.push_back(0);
        init = 1'b1; step(); init = 1'b0;
        expect_done("t7");
        step();
        chk("t7_done_pulse", 32'(done), 0);

        // async reset mid-clear
        epochs = 8'd2;
        init = 1'b1; step(); init = 1'b0;
        f_end = 1'b1; step(); f_end = 1'b0;
        b_end = 4'hf; step(); b_end = '0;
        chk("t8_clr", 32'({zl, busy}), 32'b11);
        #2 rst_n = 1'b0;
        #1;
        chk("t8_async_outs", 32'(outs()), 0);
        chk("t8_async_epoch", 32'(epoch), 0);
        step(); rst_n = 1'b1; step();
        chk("t8_after_reset", 32'(busy), 0);

        chk("sb_empty", 32'(sb.size()), 0);
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_assert, n_fail);
        $finish;
    end

endmodule
